// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the memory port sequencer
//
// Purpose: master index constants, owner-code enum as delivered by the arbiter,
// per-master context FSM states and the burst context record.
// Ports: none (package).

package ctrl_pkg;

  localparam int NUM_M  = 3;
  localparam int M1     = 0;
  localparam int M2     = 1;
  localparam int M3     = 2;

  // Context storage widths; the top-level AW/LW default to these.
  localparam int CTX_AW = 8;
  localparam int CTX_LW = 4;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    OWN_M1 = 2'b01,
    OWN_M2 = 2'b10,
    OWN_M3 = 2'b11
  } owner_e;

  typedef enum logic {
    CTX_IDLE   = 1'b0,
    CTX_ACTIVE = 1'b1
  } ctx_state_e;

  typedef struct packed {
    logic              busy;
    logic [CTX_AW-1:0] addr;
    logic [CTX_LW-1:0] remaining;
    logic              we;
  } burst_ctx_t;

  function automatic logic [NUM_M-1:0] owner_onehot(input owner_e o);
    logic [NUM_M-1:0] oh;
    oh = '0;
    case (o)
      OWN_M1:  oh[M1] = 1'b1;
      OWN_M2:  oh[M2] = 1'b1;
      OWN_M3:  oh[M3] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_burst_ctx.sv
// rtl/mem_burst_ctx.sv - one master's burst context with load, beat and error logic
//
// Purpose: holds a single burst descriptor (address, beats left, direction) and
// advances it one beat per cycle while its master owns the port.
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   own            this master is the current port owner
//   start          descriptor load strobe
//   addr_in        descriptor start address
//   len_in         descriptor beat count (0 is rejected)
//   we_in          descriptor direction, 1 = write
//   ctx_o          registered context state
//   beat           a beat is issued for this context this cycle
//   load_err       sticky descriptor-rejected flag

module mem_burst_ctx
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              own,
  input  logic              start,
  input  logic [CTX_AW-1:0] addr_in,
  input  logic [CTX_LW-1:0] len_in,
  input  logic              we_in,
  output burst_ctx_t        ctx_o,
  output logic              beat,
  output logic              load_err
);

  burst_ctx_t ctx_q, ctx_d;
  logic       load_err_q, load_err_d;
  ctx_state_e state;

  // The busy flag doubles as the IDLE/ACTIVE state register.
  assign state = ctx_q.busy ? CTX_ACTIVE : CTX_IDLE;

  always_comb begin
    ctx_d      = ctx_q;
    load_err_d = load_err_q;
    beat       = 1'b0;

    case (state)
      CTX_ACTIVE: begin
        if (own) begin
          beat            = 1'b1;
          ctx_d.addr      = ctx_q.addr + CTX_AW'(1);
          ctx_d.remaining = ctx_q.remaining - CTX_LW'(1);
          if (ctx_q.remaining == CTX_LW'(1)) begin
            ctx_d.busy = 1'b0;
          end
        end
      end
      default: ;
    endcase

    // Checking the post-beat busy flag lets a new descriptor land on the
    // same edge as the final beat of the old one; the new one overwrites.
    if (start) begin
      if ((len_in != '0) && !ctx_d.busy) begin
        ctx_d.busy      = 1'b1;
        ctx_d.addr      = addr_in;
        ctx_d.remaining = len_in;
        ctx_d.we        = we_in;
      end else begin
        load_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctx_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      ctx_q      <= ctx_d;
      load_err_q <= load_err_d;
    end
  end

  assign ctx_o    = ctx_q;
  assign load_err = load_err_q;

endmodule

// File: rtl/mem_port_sequencer.sv
// rtl/mem_port_sequencer.sv - drives the shared memory port from three resumable burst contexts
//
// Purpose: decodes the arbiter owner code, issues one beat per cycle from the
// owner's context, returns read data tagged with the beat's master, reports
// done to the arbiter and counts mid-burst ownership losses.
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   accmodule        owner code: 00 none, 01 M1, 10 M2, 11 M3
//   m_start/m_addr/m_len/m_we/m_wdata  per-master descriptor and write data, slice i = master i
//   done             combinational owner-finishing/idle indication
//   busy, load_err   per-context busy and sticky rejection flags
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory port, mem_rdata its read data
//   m_rdata, m_rvalid  read data broadcast and one-hot tag
//   suspend_cnt      saturating count of mid-burst ownership losses

module mem_port_sequencer
  import ctrl_pkg::*;
#(
  parameter int AW = CTX_AW,
  parameter int DW = 16,
  parameter int LW = CTX_LW,
  parameter int CW = 16
) (
  input  logic [0:0]        clk,
  input  logic [0:0]        reset,
  input  logic [1:0]        accmodule,
  input  logic [2:0]        m_start,
  input  logic [3*AW-1:0]   m_addr,
  input  logic [3*LW-1:0]   m_len,
  input  logic [2:0]        m_we,
  input  logic [3*DW-1:0]   m_wdata,
  output logic [2:0]        done,
  output logic [2:0]        busy,
  output logic [2:0]        load_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [DW-1:0]     m_rdata,
  output logic [2:0]        m_rvalid,
  output logic [CW-1:0]     suspend_cnt
);

  owner_e           own_code;
  logic [NUM_M-1:0] own_oh;
  burst_ctx_t       ctx [NUM_M];
  logic [NUM_M-1:0] beat;
  logic             suspend;

  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic [NUM_M-1:0] beat_q, beat_d;
  logic [NUM_M-1:0] m_rvalid_q, m_rvalid_d;
  logic [DW-1:0]    m_rdata_q, m_rdata_d;
  logic [CW-1:0]    suspend_cnt_q, suspend_cnt_d;

  assign own_code = owner_e'(accmodule);
  assign own_oh   = owner_onehot(own_code);

  for (genvar i = 0; i < NUM_M; i++) begin : g_ctx
    mem_burst_ctx u_ctx (
      .clk      (clk),
      .reset    (reset),
      .own      (own_oh[i]),
      .start    (m_start[i]),
      .addr_in  (m_addr[i*AW +: AW]),
      .len_in   (m_len[i*LW +: LW]),
      .we_in    (m_we[i]),
      .ctx_o    (ctx[i]),
      .beat     (beat[i]),
      .load_err (load_err[i])
    );
    assign busy[i] = ctx[i].busy;
  end

  // done is combinational so the arbiter sees it in the first grant cycle.
  always_comb begin
    done = '0;
    for (int i = 0; i < NUM_M; i++) begin
      done[i] = own_oh[i] & (~ctx[i].busy | (ctx[i].remaining == CTX_LW'(1)));
    end
  end

  always_comb begin
    mem_en_d    = |beat;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // beat is at most one-hot since only the owner can issue.
    for (int i = 0; i < NUM_M; i++) begin
      if (beat[i]) begin
        mem_we_d    = ctx[i].we;
        mem_addr_d  = ctx[i].addr;
        mem_wdata_d = m_wdata[i*DW +: DW];
      end
    end
    beat_d = beat;

    // The read tag comes from the registered beat owner, not the current
    // accmodule, so it stays correct across an ownership change.
    m_rvalid_d = mem_we_q ? '0 : beat_q;
    m_rdata_d  = (!mem_we_q && (|beat_q)) ? mem_rdata : m_rdata_q;

    // Last cycle's beat context is still busy but someone else (or nobody)
    // owns the port now: that burst has been suspended.
    suspend       = |(beat_q & busy & ~own_oh);
    suspend_cnt_d = suspend_cnt_q;
    if (suspend && (suspend_cnt_q != {CW{1'b1}})) begin
      suspend_cnt_d = suspend_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      beat_q        <= '0;
      m_rvalid_q    <= '0;
      m_rdata_q     <= '0;
      suspend_cnt_q <= '0;
    end else begin
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      beat_q        <= beat_d;
      m_rvalid_q    <= m_rvalid_d;
      m_rdata_q     <= m_rdata_d;
      suspend_cnt_q <= suspend_cnt_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign m_rvalid    = m_rvalid_q;
  assign m_rdata     = m_rdata_q;
  assign suspend_cnt = suspend_cnt_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb/tb_mem_port_sequencer.sv - self-checking bench for mem_port_sequencer

module tb_mem_port_sequencer;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LW = 4;
  localparam int CW = 2;

  localparam logic [1:0] PRE_OWN  [5] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
  localparam int         PRE_ADDR [5] = '{'h20, 'h40, 'h21, 'h22, 'h23};

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      accmodule;
  logic [2:0]      m_start;
  logic [3*AW-1:0] m_addr;
  logic [3*LW-1:0] m_len;
  logic [2:0]      m_we;
  logic [3*DW-1:0] m_wdata;
  logic [2:0]      done, busy, load_err;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata, m_rdata;
  logic [2:0]      m_rvalid;
  logic [CW-1:0]   suspend_cnt;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return {a ^ 8'hA5, ~a};
  endfunction

  // Memory answers from the address it is currently being presented.
  assign mem_rdata = (mem_en && !mem_we) ? rd_fn(mem_addr) : 16'hDEAD;

  mem_port_sequencer #(.AW(AW), .DW(DW), .LW(LW), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .accmodule   (accmodule),
    .m_start     (m_start),
    .m_addr      (m_addr),
    .m_len       (m_len),
    .m_we        (m_we),
    .m_wdata     (m_wdata),
    .done        (done),
    .busy        (busy),
    .load_err    (load_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .m_rdata     (m_rdata),
    .m_rvalid    (m_rvalid),
    .suspend_cnt (suspend_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-master descriptor progress plus expected port state.
  bit mb [3];
  int ma [3];
  int mr [3];
  bit mw [3];
  bit merr [3];
  bit e_en, e_we;
  int e_addr, e_wdata, e_bown, e_rvalid, e_rdata, e_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int own_idx();
    return (accmodule == 2'b00) ? -1 : int'(accmodule) - 1;
  endfunction

  function automatic logic [2:0] model_done();
    logic [2:0] d;
    int o;
    d = 3'b000;
    o = own_idx();
    if (o >= 0) begin
      if (!mb[o] || mr[o] == 1) d[o] = 1'b1;
    end
    return d;
  endfunction

  task automatic model_step();
    int o;
    int len;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        mb[i] = 0; ma[i] = 0; mr[i] = 0; mw[i] = 0; merr[i] = 0;
      end
      e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_bown = 0;
      e_rvalid = 0; e_rdata = 0; e_cnt = 0;
      return;
    end
    o = own_idx();
    if (e_en && !e_we) begin
      e_rvalid = 1 << e_bown;
      e_rdata  = int'(rd_fn(AW'(e_addr)));
    end else begin
      e_rvalid = 0;
    end
    if (e_en && mb[e_bown] && o != e_bown && e_cnt < (1 << CW) - 1) e_cnt++;
    if (o >= 0 && mb[o]) begin
      e_en    = 1;
      e_we    = mw[o];
      e_addr  = ma[o];
      e_wdata = int'(m_wdata[o*DW +: DW]);
      e_bown  = o;
      ma[o]   = (ma[o] + 1) % (1 << AW);
      mr[o]   = mr[o] - 1;
      if (mr[o] == 0) mb[o] = 0;
    end else begin
      e_en = 0;
    end
    // A context that is idle after this cycle's beat may take a new descriptor.
    for (int i = 0; i < 3; i++) begin
      if (m_start[i]) begin
        len = int'(m_len[i*LW +: LW]);
        if (len != 0 && !mb[i]) begin
          mb[i] = 1;
          ma[i] = int'(m_addr[i*AW +: AW]);
          mr[i] = len;
          mw[i] = m_we[i];
        end else begin
          merr[i] = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [2:0] vb, ve;
    for (int i = 0; i < 3; i++) begin
      vb[i] = mb[i];
      ve[i] = merr[i];
    end
    check("mem_en", mem_en, e_en);
    if (e_en) begin
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
    end
    check("m_rvalid", m_rvalid, e_rvalid);
    check("m_rdata", m_rdata, e_rdata);
    check("suspend_cnt", suspend_cnt, e_cnt);
    check("busy", busy, vb);
    check("load_err", load_err, ve);
  endtask

  task automatic tick();
    #1;
    check("done", done, model_done());
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic load(input int i, input int a, input int len, input bit we);
    m_start[i] = 1'b1;
    m_addr[i*AW +: AW] = AW'(a);
    m_len[i*LW +: LW] = LW'(len);
    m_we[i] = we;
  endtask

  initial begin
    reset = 1'b0; accmodule = 2'b00; m_start = '0; m_addr = '0;
    m_len = '0; m_we = '0; m_wdata = '0;

    tick();
    tick();
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b1;

    // M3 write burst of three beats
    load(2, 'h10, 3, 1'b1);
    tick();
    m_start = '0;
    accmodule = 2'b11;
    for (int k = 0; k < 3; k++) begin
      m_wdata[2*DW +: DW] = DW'(16'h3000 + k);
      #1 check("m3_done", done, (k == 2) ? 3'b100 : 3'b000);
      tick();
      check("m3_addr", mem_addr, 'h10 + k);
      check("m3_wdata", mem_wdata, 16'h3000 + k);
    end

    // owner points at an idle context
    #1 check("idle_done", done, 3'b100);
    tick();
    check("idle_en", mem_en, 0);

    // M2 preempted by a one-beat M1 burst
    accmodule = 2'b00;
    load(1, 'h20, 4, 1'b0);
    load(0, 'h40, 1, 1'b0);
    tick();
    m_start = '0;
    for (int k = 0; k < 5; k++) begin
      accmodule = PRE_OWN[k];
      tick();
      check("pre_addr", mem_addr, PRE_ADDR[k]);
    end
    accmodule = 2'b00;
    tick();
    check("pre_susp", suspend_cnt, 1);

    // address wrap on an M1 read burst
    load(0, 'hFE, 3, 1'b0);
    tick();
    m_start = '0;
    accmodule = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wrap_addr", mem_addr, ('hFE + k) % 256);
      if (k > 0) check("wrap_rvalid", m_rvalid, 3'b001);
    end
    accmodule = 2'b00;
    tick();
    check("wrap_rvalid_last", m_rvalid, 3'b001);
    check("wrap_rdata_last", m_rdata, rd_fn(8'h00));

    // rejected descriptors
    load(0, 'h50, 0, 1'b1);
    tick();
    m_start = '0;
    check("err_len0", load_err[0], 1);
    load(1, 'h30, 4, 1'b1);
    tick();
    m_start = '0;
    accmodule = 2'b10;
    tick();
    load(1, 'h80, 2, 1'b0);
    tick();
    m_start = '0;
    check("err_busy", load_err[1], 1);
    check("err_keep_addr", mem_addr, 'h31);
    tick();
    // load on the final beat: the new descriptor takes over
    load(1, 'h90, 2, 1'b0);
    tick();
    m_start = '0;
    check("simul_addr", mem_addr, 'h33);
    check("simul_busy", busy[1], 1);
    tick();
    check("simul_first", mem_addr, 'h90);

    // suspension counter saturation
    accmodule = 2'b00;
    load(2, 'h60, 15, 1'b1);
    tick();
    m_start = '0;
    for (int k = 0; k < 5; k++) begin
      accmodule = 2'b11;
      tick();
      accmodule = 2'b00;
      tick();
    end
    check("sat_cnt", suspend_cnt, 3);

    // reset in the middle of an M2 burst
    accmodule = 2'b10;
    tick();
    accmodule = 2'b00;
    load(1, 'hA0, 4, 1'b0);
    tick();
    m_start = '0;
    accmodule = 2'b10;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_en", mem_en, 0);
    check("rst_susp", suspend_cnt, 0);
    tick();
    check("no_resume", mem_en, 0);

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      accmodule = 2'($urandom_range(0, 3));
      m_start = '0;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          load(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
      end
      m_wdata = {16'($urandom), 16'($urandom), 16'($urandom)};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
